// File: rtl/recovery_loader_if.sv
// Byte-stream input and memory-bus signals of the recovery loader.
// master = loader side, slave = stream source plus memory responder.
interface recovery_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_ready, mem_rdata,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output in_valid, in_data, mem_ready, mem_rdata,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/recovery_loader.sv
// Parses MAGIC/addr/len/payload frames from a byte stream and writes them to memory
// as word-aligned strobed writes. Define LOADER_VERIFY_EN to read back and compare each word.
module recovery_loader #(
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  recovery_loader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_VERIFY, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [29:0] buf_word_q, buf_word_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  buf_strb_q, buf_strb_d;
  logic [31:0] tmo_q, tmo_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        word_done;
  logic [1:0]  lane;

  assign accept = bus.in_valid && in_ready_q;
  assign lane   = addr_q[1:0];

`ifdef LOADER_VERIFY_EN
  logic [31:0] lane_mask;
  logic        rd_mismatch;

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{buf_strb_q[i]}};
    end
    rd_mismatch = |((bus.mem_rdata ^ buf_data_q) & lane_mask);
  end
`else
  logic rdata_unused;
  assign rdata_unused = ^bus.mem_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    buf_strb_d  = buf_strb_q;
    tmo_d       = tmo_q;
    in_ready_d  = in_ready_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    err_d       = err_q;
    done_d      = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (accept && bus.in_data == MAGIC) begin
          state_d    = S_HDR;
          err_d      = 1'b0;
          hdr_cnt_d  = '0;
          buf_data_d = '0;
          buf_strb_d = '0;
        end
      end

      S_HDR: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          // Little-endian: shift each byte in from the top
          if (!hdr_cnt_q[2]) addr_d = {bus.in_data, addr_q[31:8]};
          else               len_d  = {bus.in_data, len_q[31:8]};
          if (hdr_cnt_q == 3'd7) begin
            if ({bus.in_data, len_q[31:8]} == '0) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              in_ready_d = 1'b0;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          buf_data_d[{lane, 3'b000} +: 8] = bus.in_data;
          buf_strb_d[lane]                = 1'b1;
          buf_word_d                      = addr_q[31:2];
          addr_d                          = addr_q + 32'd1;
          len_d                           = len_q - 32'd1;
          if (lane == 2'd3 || len_q == 32'd1) begin
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
          end
        end
      end

      S_WRITE: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {buf_word_q, 2'b00};
          mem_wdata_d = buf_data_q;
          mem_wstrb_d = buf_strb_q;
          tmo_d       = '0;
        end else if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
`ifdef LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          word_done = 1'b1;
`endif
        end else if (tmo_q == TIMEOUT - 1) begin
          mem_valid_d = 1'b0;
          state_d     = S_ERR;
          err_d       = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_wstrb_d = '0;
          tmo_d       = '0;
        end else if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          if (rd_mismatch) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            word_done = 1'b1;
          end
        end else if (tmo_q == TIMEOUT - 1) begin
          mem_valid_d = 1'b0;
          state_d     = S_ERR;
          err_d       = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
`endif

      S_DONE: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end

      S_ERR: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        mem_valid_d = 1'b0;
      end
    endcase

    // Shared completion path for a finished (and, if enabled, verified) word
    if (word_done) begin
      buf_data_d = '0;
      buf_strb_d = '0;
      if (len_q == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d    = S_DATA;
        in_ready_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
      buf_strb_q  <= buf_strb_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_recovery_loader.sv
// Directed bench for recovery_loader: byte-stream driver, memory responder with
// programmable ready delay / hang, and hand-computed expected writes.
module tb_recovery_loader;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, done, err;

  recovery_loader_if bus();

  recovery_loader #(.MAGIC(8'hA5), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder controls and observations
  logic          hang        = 1'b0;
  int unsigned   ready_delay = 0;
  logic          rdata_zero  = 1'b0;
  logic [31:0]   log_addr[$];
  logic [31:0]   log_data[$];
  logic [3:0]    log_strb[$];
  logic [31:0]   mem_model[logic [31:0]];
  int unsigned   stab_viol  = 0;
  int unsigned   inrdy_viol = 0;
  int unsigned   gap_viol   = 0;
  int unsigned   reads      = 0;
  int unsigned   done_cnt   = 0;
  int unsigned   wait_cnt   = 0;
  logic          prev_ready = 1'b0;
  logic [31:0]   cap_addr, cap_data, merged;
  logic [3:0]    cap_strb;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (prev_ready && bus.mem_valid) gap_viol++;
      prev_ready    = 1'b0;
      bus.mem_ready = 1'b0;
      if (bus.mem_valid) begin
        if (bus.in_ready) inrdy_viol++;
        if (wait_cnt == 0) begin
          cap_addr = bus.mem_addr;
          cap_data = bus.mem_wdata;
          cap_strb = bus.mem_wstrb;
          if (bus.mem_wstrb == 4'b0000) reads++;
        end else if (bus.mem_addr !== cap_addr || bus.mem_wdata !== cap_data ||
                     bus.mem_wstrb !== cap_strb) begin
          stab_viol++;
        end
        if (!hang && wait_cnt >= ready_delay) begin
          bus.mem_ready = 1'b1;
          prev_ready    = 1'b1;
          wait_cnt      = 0;
          if (bus.mem_wstrb != 4'b0000) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
            log_strb.push_back(bus.mem_wstrb);
            merged = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : '0;
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem_model[bus.mem_addr] = merged;
          end else begin
            bus.mem_rdata = (rdata_zero || !mem_model.exists(bus.mem_addr)) ?
                            32'h0 : mem_model[bus.mem_addr];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [31:0] l);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  int base;
  int unsigned d0, hi, n;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mem_addr",  bus.mem_addr,           32'd0);
    check("rst_mem_wdata", bus.mem_wdata,          32'd0);
    check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_done",      {31'd0, done},          32'd0);
    check("rst_err",       {31'd0, err},           32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Aligned load: two full words
    base = log_addr.size();
    d0   = done_cnt;
    send_hdr(32'h0000_0100, 32'd8);
    for (int i = 0; i < 8; i++) send_byte(8'h11 + i[7:0]);
    wait_idle();
    check("t1_nwrites", log_addr.size() - base, 32'd2);
    check("t1_w0_addr", log_addr[base],     32'h0000_0100);
    check("t1_w0_data", log_data[base],     32'h1413_1211);
    check("t1_w0_strb", {28'd0, log_strb[base]},   32'hF);
    check("t1_w1_addr", log_addr[base + 1], 32'h0000_0104);
    check("t1_w1_data", log_data[base + 1], 32'h1817_1615);
    check("t1_w1_strb", {28'd0, log_strb[base + 1]}, 32'hF);
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);

    // Unaligned start and end
    base = log_addr.size();
    d0   = done_cnt;
    send_hdr(32'h0000_0203, 32'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_idle();
    check("t2_nwrites", log_addr.size() - base, 32'd2);
    check("t2_w0_addr", log_addr[base],     32'h0000_0200);
    check("t2_w0_data", log_data[base],     32'hAA00_0000);
    check("t2_w0_strb", {28'd0, log_strb[base]},   32'h8);
    check("t2_w1_addr", log_addr[base + 1], 32'h0000_0204);
    check("t2_w1_data", log_data[base + 1], 32'h0000_CCBB);
    check("t2_w1_strb", {28'd0, log_strb[base + 1]}, 32'h3);
    check("t2_done_pulses", done_cnt - d0, 32'd1);

    // Garbage then zero-length frame
    send_byte(8'h00);
    check("t3_garbage_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h7F);
    base = log_addr.size();
    d0   = done_cnt;
    send_hdr(32'h0, 32'h0);
    check("t3_done_hi", {31'd0, done}, 32'd1);
    check("t3_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t3_done_lo", {31'd0, done}, 32'd0);
    check("t3_busy_lo", {31'd0, busy}, 32'd0);
    check("t3_nwrites", log_addr.size() - base, 32'd0);
    check("t3_done_pulses", done_cnt - d0, 32'd1);

    // Timeout with a responder that never answers
    hang = 1'b1;
    base = log_addr.size();
    send_hdr(32'h0000_0300, 32'd1);
    send_byte(8'h5A);
    n = 0;
    while (!bus.mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (bus.mem_valid && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check("t4_valid_cycles", hi, TMO);
    check("t4_err", {31'd0, err}, 32'd1);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_err_sticky", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00);
    check("t4_err_sticky_garbage", {31'd0, err}, 32'd1);
    d0 = done_cnt;
    send_byte(8'hA5);
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(8'h00);
    @(negedge clk);
    check("t4_nwrites", log_addr.size() - base, 32'd0);
    check("t4_done_pulses", done_cnt - d0, 32'd1);

    // Backpressure: ready after 5 waiting cycles
    ready_delay = 5;
    stab_viol   = 0;
    inrdy_viol  = 0;
    base = log_addr.size();
    send_hdr(32'h0000_0400, 32'd6);
    for (int i = 0; i < 6; i++) send_byte(8'h21 + i[7:0]);
    wait_idle();
    ready_delay = 0;
    check("t5_nwrites", log_addr.size() - base, 32'd2);
    check("t5_w0_addr", log_addr[base],     32'h0000_0400);
    check("t5_w0_data", log_data[base],     32'h2423_2221);
    check("t5_w1_addr", log_addr[base + 1], 32'h0000_0404);
    check("t5_w1_data", log_data[base + 1], 32'h0000_2625);
    check("t5_w1_strb", {28'd0, log_strb[base + 1]}, 32'h3);
    check("t5_stable", stab_viol, 32'd0);
    check("t5_in_ready_low", inrdy_viol, 32'd0);
    check("idle_gap", gap_viol, 32'd0);

`ifdef LOADER_VERIFY_EN
    // Readback returns zeros: must flag error and skip done
    rdata_zero = 1'b1;
    d0 = done_cnt;
    send_hdr(32'h0000_0500, 32'd4);
    for (int i = 0; i < 4; i++) send_byte(8'h11 + i[7:0]);
    wait_idle();
    rdata_zero = 1'b0;
    check("t6_verify_err", {31'd0, err}, 32'd1);
    check("t6_no_done", done_cnt - d0, 32'd0);
`else
    check("no_reads", reads, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
